// File: rtl/nios2_mulx_seq.sv
// Sequential Nios II style multiplier: one SLICE x SLICE partial product per cycle,
// then a single signed-correction cycle, covering MUL / MULXUU / MULXSU / MULXSS.
module nios2_mulx_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int K  = WIDTH / SLICE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, CORR, DONE} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  src1_reg;
    logic [WIDTH-1:0]  src2_reg;
    logic [1:0]        op_reg;
    logic [AW-1:0]     acc_reg;
    logic [CW-1:0]     i_reg;
    logic [CW-1:0]     j_reg;
    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_result_reg;

    logic [SLICE-1:0]   a_slice [K];
    logic [SLICE-1:0]   b_slice [K];
    logic [2*SLICE-1:0] pp;
    logic [AW-1:0]      pp_shift;
    logic [AW-1:0]      sub1;
    logic [AW-1:0]      sub2;
    logic [AW-1:0]      acc_corr;
    int unsigned        shamt;
    logic               last_pp;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slice
            assign a_slice[gi] = src1_reg[gi*SLICE +: SLICE];
            assign b_slice[gi] = src2_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    always_comb begin
        pp       = {{SLICE{1'b0}}, a_slice[i_reg]} * {{SLICE{1'b0}}, b_slice[j_reg]};
        shamt    = (int'(i_reg) + int'(j_reg)) * SLICE;
        pp_shift = AW'(pp) << shamt;
        last_pp  = (i_reg == CW'(K - 1)) && (j_reg == CW'(K - 1));
    end

    // The unsigned sum over-counts by 2^WIDTH * other operand for each negative signed operand.
    always_comb begin
        sub1     = '0;
        sub2     = '0;
        if (op_reg[1] && src1_reg[WIDTH-1])
            sub1 = {src2_reg, {WIDTH{1'b0}}};
        if ((op_reg == 2'b11) && src2_reg[WIDTH-1])
            sub2 = {src1_reg, {WIDTH{1'b0}}};
        acc_corr = acc_reg - sub1 - sub2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            src1_reg       <= '0;
            src2_reg       <= '0;
            op_reg         <= '0;
            acc_reg        <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && !flush) begin
                        src1_reg  <= in_src1;
                        src2_reg  <= in_src2;
                        op_reg    <= in_op;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg <= acc_reg + pp_shift;
                        if (i_reg == CW'(K - 1)) begin
                            i_reg <= '0;
                            j_reg <= j_reg + 1'b1;
                        end else begin
                            i_reg <= i_reg + 1'b1;
                        end
                        if (last_pp)
                            state_reg <= CORR;
                    end
                end
                CORR: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg        <= acc_corr;
                        out_result_reg <= (op_reg == 2'b00) ? acc_corr[WIDTH-1:0]
                                                            : acc_corr[AW-1:WIDTH];
                        out_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;

endmodule

// File: tb/tb_nios2_mulx_seq.sv
// Directed vector table for the 32-bit configuration, handshake/flush/reset sequences,
// and a 64-bit sweep against a wide-multiply reference.
module tb_nios2_mulx_seq;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;

    logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
    logic [1:0]  w_in_op;
    logic [63:0] w_in_src1, w_in_src2, w_out_result;

    nios2_mulx_seq #(.WIDTH(32), .SLICE(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    nios2_mulx_seq #(.WIDTH(64), .SLICE(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_op(w_in_op), .in_src1(w_in_src1), .in_src2(w_in_src2), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Changes operands right after acceptance so a design that reads live inputs is caught.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_src1  = ~a;
        in_src2  = b ^ 32'h5A5A_5A5A;
        in_op    = ~op;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
    endtask

    task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        w_in_op    = op;
        w_in_src1  = a;
        w_in_src2  = b;
        w_in_valid = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0;
        w_in_src1  = ~a;
        w_in_op    = ~op;
        lat = 0;
        while (w_out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = w_out_result;
    endtask

    function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] x, y, p;
        x = op[1] ? {{64{a[63]}}, a} : {64'b0, a};
        y = (op == 2'b11) ? {{64{b[63]}}, b} : {64'b0, b};
        p = x * y;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic watch_no_valid(input string name, input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [63:0] res64, a64, b64, e64;
        logic [31:0] held;
        int lat;

        vecs[0]  = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        vecs[1]  = '{2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
        vecs[9]  = '{2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};
        vecs[10] = '{2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[11] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[12] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
        vecs[13] = '{2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};

        reset = 1'b1;
        in_valid = 0; in_op = 0; in_src1 = 0; in_src2 = 0; flush = 0; out_ready = 1;
        w_in_valid = 0; w_in_op = 0; w_in_src1 = 0; w_in_src2 = 0; w_flush = 0; w_out_ready = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_in_ready64", 64'(w_in_ready), 64'd1);

        for (int v = 0; v < 14; v++) begin
            check("pre_in_ready", 64'(in_ready), 64'd1);
            run32(vecs[v].op, vecs[v].a, vecs[v].b, res, lat);
            $display("vec %0d op=%0d a=0x%08h b=0x%08h result=0x%08h expected=0x%08h latency=%0d",
                     v, vecs[v].op, vecs[v].a, vecs[v].b, res, vecs[v].exp, lat);
            check("vec_result", 64'(res), 64'(vecs[v].exp));
            check("vec_latency", 64'(lat), 64'd5);
            check("vec_in_ready_done", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("vec_consumed", 64'(out_valid), 64'd0);
            check("vec_in_ready_after", 64'(in_ready), 64'd1);
        end

        // Flush while idle must not start an operation.
        in_valid = 1'b1; flush = 1'b1; in_op = 2'b00; in_src1 = 32'd9; in_src2 = 32'd9;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_blocks", 64'(in_ready), 64'd1);
        $display("idle flush: in_ready=%0d", in_ready);
        watch_no_valid("idle_flush_no_valid", 8);

        // Back-pressure: result held for 10 cycles.
        out_ready = 1'b0;
        run32(2'b00, 32'h0001_0003, 32'h0002_0005, res, lat);
        held = res;
        check("hold_result", 64'(res), 64'h000B_000F);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_stable", 64'(out_result), 64'(held));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release", 64'(out_valid), 64'd0);
        check("hold_in_ready_after", 64'(in_ready), 64'd1);
        $display("hold: result=0x%08h released", held);
        watch_no_valid("hold_single_delivery", 6);

        // Flush in MUL cycle 2.
        in_op = 2'b00; in_src1 = 32'd5; in_src2 = 32'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        $display("flush mid-MUL: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        watch_no_valid("flush_no_valid", 10);

        // Reset in MUL cycle 3.
        in_op = 2'b01; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_in_ready", 64'(in_ready), 64'd1);
        check("reset_mid_out_result", 64'(out_result), 64'd0);
        $display("reset mid-MUL: in_ready=%0d out_result=0x%08h", in_ready, out_result);
        watch_no_valid("reset_mid_no_valid", 10);

        run32(2'b00, 32'd3, 32'd7, res, lat);
        $display("post-abort MUL 3x7: result=0x%08h latency=%0d", res, lat);
        check("post_abort_result", 64'(res), 64'h15);
        check("post_abort_latency", 64'(lat), 64'd5);
        @(negedge clk);

        // 64-bit sweep.
        for (int n = 0; n < 16; n++) begin
            case (n / 4)
                0: begin a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'hFFFF_FFFF_FFFF_FFFF; end
                1: begin a64 = 64'h8000_0000_0000_0000; b64 = 64'h8000_0000_0000_0001; end
                default: begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
            endcase
            e64 = ref64(2'(n % 4), a64, b64);
            run64(2'(n % 4), a64, b64, res64, lat);
            $display("w64 %0d op=%0d a=0x%016h b=0x%016h result=0x%016h expected=0x%016h latency=%0d",
                     n, n % 4, a64, b64, res64, e64, lat);
            check("w64_result", res64, e64);
            check("w64_latency", 64'(lat), 64'd17);
            @(negedge clk);
            check("w64_consumed", 64'(w_out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
